// File: rtl/ram_hs_param.sv
// ram_hs_param: byte-addressed RAM behind a four-phase mov/moc handshake.
//
// A request is captured in IDLE when mov is high. Legal accesses spend
// WAIT_CYCLES extra cycles in WAIT, perform the array access on the edge
// that leaves WAIT, then sit in DONE until mov drops. Misaligned or
// illegal-size requests go straight to ERR and touch nothing.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   mov        : request valid (held high until moc is seen, then dropped)
//   rw         : 1 = read, 0 = write
//   size       : 00 byte, 01 halfword, 10 word, 11 illegal
//   sgn        : sign-extend byte/halfword reads
//   addr       : byte address
//   data_in    : write data, right-aligned
//   data_out   : read data, right-aligned and extended; held until next read
//   moc        : operation complete (DONE or ERR)
//   busy       : any state other than IDLE
//   align_err  : request rejected; meaningful while moc is high
module ram_hs_param #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              busy,
  output logic              align_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [1:0]        r_size;
  logic              r_sgn;
  logic [31:0]       r_din;
  logic [31:0]       r_dout;

  // Byte array; intentionally not reset so contents survive reset.
  reg   [7:0]        Mem [0:(1<<ADDR_W)-1];

  logic              w_misalign;
  logic              w_access;
  logic [2:0]        w_nbytes;
  logic [31:0]       w_rd_raw;
  logic [31:0]       w_rd_ext;

  assign w_misalign = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

  // The access happens on the single edge that leaves WAIT.
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    case (r_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Accesses are naturally aligned, so addr|i equals addr+i for every byte
  // of the access and can never carry past the top of the array.
  always_comb begin
    w_rd_raw = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(w_nbytes))
        w_rd_raw[8*(BIG_ENDIAN ? int'(w_nbytes)-1-i : i) +: 8] = Mem[r_addr | ADDR_W'(i)];
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_rd_ext = {{24{r_sgn & w_rd_raw[7]}},  w_rd_raw[7:0]};
      2'b01:   w_rd_ext = {{16{r_sgn & w_rd_raw[15]}}, w_rd_raw[15:0]};
      default: w_rd_ext = w_rd_raw;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mov) begin
          if (w_misalign) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) w_cnt_nxt   = r_cnt - 4'd1;
        else               w_state_nxt = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (!mov) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_size  <= '0;
      r_sgn   <= 1'b0;
      r_din   <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && mov) begin
        r_addr <= addr;
        r_rw   <= rw;
        r_size <= size;
        r_sgn  <= sgn;
        r_din  <= data_in;
      end
      if (w_access && r_rw) r_dout <= w_rd_ext;
    end
  end

  // Async reset drops r_state out of WAIT immediately, so an aborted
  // access never reaches this write.
  always_ff @(posedge clk) begin
    if (w_access && !r_rw) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(w_nbytes))
          Mem[r_addr | ADDR_W'(i)] <= r_din[8*(BIG_ENDIAN ? int'(w_nbytes)-1-i : i) +: 8];
      end
    end
  end

  assign data_out  = r_dout;
  assign moc       = (r_state == S_DONE) || (r_state == S_ERR);
  assign align_err = (r_state == S_ERR);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_hs_param.sv
module tb_ram_hs_param;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          mov_a, mov_b, rw, sgn;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic [31:0]   dout_a, dout_b;
  logic          moc_a, moc_b, busy_a, busy_b, err_a, err_b;

  always #5 clk = ~clk;

  ram_hs_param #(.ADDR_W(AW), .WAIT_CYCLES(2), .BIG_ENDIAN(1'b1)) u_a (
    .clk(clk), .reset(reset), .mov(mov_a), .rw(rw), .size(size), .sgn(sgn),
    .addr(addr), .data_in(din), .data_out(dout_a), .moc(moc_a),
    .busy(busy_a), .align_err(err_a));

  ram_hs_param #(.ADDR_W(AW), .WAIT_CYCLES(0), .BIG_ENDIAN(1'b0)) u_b (
    .clk(clk), .reset(reset), .mov(mov_b), .rw(rw), .size(size), .sgn(sgn),
    .addr(addr), .data_in(din), .data_out(dout_b), .moc(moc_b),
    .busy(busy_b), .align_err(err_b));

  typedef struct packed {
    logic          sel;   // 0 = u_a (2 waits, BE), 1 = u_b (0 waits, LE)
    logic          rw;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [31:0]   dout;  // expected data_out after completion
    logic          err;   // expected align_err
  } vec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [1:0] z,
                              input logic g, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic [31:0] o, input logic e);
    vec_t v;
    v.sel = s; v.rw = r; v.size = z; v.sgn = g; v.addr = a;
    v.din = d; v.dout = o; v.err = e;
    return v;
  endfunction

  // Full handshake. Latency is counted in edges from the capture edge
  // inclusive: WAIT_CYCLES+2 for a legal access, 1 for a rejected one.
  task automatic run_req(input vec_t v);
    vec_t e;
    int   lat;
    int   lat_exp;
    logic m;
    @(negedge clk);
    rw = v.rw; size = v.size; sgn = v.sgn; addr = v.addr; din = v.din;
    if (v.sel) mov_b = 1'b1; else mov_a = 1'b1;
    sb_q.push_back(v);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        check("busy_after_capture", 32'(v.sel ? busy_b : busy_a), 32'd1);
        // Captured fields must be immune to later input changes.
        din = ~din; addr = ~addr; rw = ~rw; sgn = ~sgn;
      end
      m = v.sel ? moc_b : moc_a;
    end while (!m && lat < 40);
    e = sb_q.pop_front();
    lat_exp = e.err ? 1 : ((e.sel ? 0 : 2) + 2);
    check("latency",   32'(lat), 32'(lat_exp));
    check("align_err", 32'(e.sel ? err_b : err_a), 32'(e.err));
    check("data_out",  e.sel ? dout_b : dout_a, e.dout);
    @(negedge clk);
    mov_a = 1'b0; mov_b = 1'b0;
    @(posedge clk); #1;
    check("moc_drop",  32'(e.sel ? moc_b : moc_a), 32'd0);
    check("busy_drop", 32'(e.sel ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0; mov_a = 1'b0; mov_b = 1'b0; rw = 1'b0; size = 2'b00;
    sgn = 1'b0; addr = '0; din = '0;

    // Preload via hierarchy; these bytes must survive reset and bad requests.
    u_a.Mem[9'h002] = 8'h11; u_a.Mem[9'h003] = 8'h22;
    u_a.Mem[9'h020] = 8'h00; u_a.Mem[9'h021] = 8'h00;
    u_a.Mem[9'h010] = 8'h01; u_a.Mem[9'h011] = 8'h02;
    u_a.Mem[9'h012] = 8'h03; u_a.Mem[9'h013] = 8'h04;

    #2;
    check("rst_dout_a", dout_a, 32'h0);
    check("rst_moc_a",  32'(moc_a),  32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_err_a",  32'(err_a),  32'd0);
    check("rst_dout_b", dout_b, 32'h0);
    check("rst_moc_b",  32'(moc_b),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    //               sel   rw    size   sgn   addr    din            exp dout       err
    tbl.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 9'h004, 32'h12345678, 32'h00000000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 9'h004, 32'h0,        32'h12345678, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 9'h005, 32'h0000009A, 32'h12345678, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 9'h005, 32'h0,        32'hFFFFFF9A, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 9'h005, 32'h0,        32'h0000009A, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 2'b01, 1'b0, 9'h006, 32'h000080FE, 32'h0000009A, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 9'h006, 32'h0,        32'hFFFF80FE, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 9'h006, 32'h0,        32'h000080FE, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 9'h004, 32'h0,        32'h129A80FE, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 2'b01, 1'b0, 9'h003, 32'h0000BEEF, 32'h129A80FE, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 9'h000, 32'h0,        32'h129A80FE, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 9'h102, 32'h11111111, 32'h129A80FE, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 9'h1FC, 32'hCAFEF00D, 32'h129A80FE, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 9'h1FC, 32'h0,        32'hCAFEF00D, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 9'h1FF, 32'h0,        32'h0000000D, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 9'h1FE, 32'h0,        32'hFFFFF00D, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 9'h1FC, 32'hAABBCCDD, 32'h00000000, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b01, 1'b1, 9'h1FE, 32'h0,        32'hFFFFAABB, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 1'b0, 9'h1FD, 32'h0,        32'h000000CC, 1'b0));

    foreach (tbl[k]) run_req(tbl[k]);

    check("a_mem4",   32'(u_a.Mem[9'h004]), 32'h12);
    check("a_mem5",   32'(u_a.Mem[9'h005]), 32'h9A);
    check("a_mem6",   32'(u_a.Mem[9'h006]), 32'h80);
    check("a_mem7",   32'(u_a.Mem[9'h007]), 32'hFE);
    check("a_mem2",   32'(u_a.Mem[9'h002]), 32'h11);
    check("a_mem3",   32'(u_a.Mem[9'h003]), 32'h22);
    check("a_mem1fc", 32'(u_a.Mem[9'h1FC]), 32'hCA);
    check("a_mem1ff", 32'(u_a.Mem[9'h1FF]), 32'h0D);
    check("b_mem1fc", 32'(u_b.Mem[9'h1FC]), 32'hDD);
    check("b_mem1ff", 32'(u_b.Mem[9'h1FF]), 32'hAA);

    // Handshake hold: mov stays high 5 cycles past moc, inputs wander.
    @(negedge clk);
    rw = 1'b0; size = 2'b00; sgn = 1'b0; addr = 9'h020; din = 32'h55; mov_a = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (!moc_a && lat < 40);
    check("hold_latency", 32'(lat), 32'd4);
    @(negedge clk);
    addr = 9'h021; din = 32'h66; size = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_moc",  32'(moc_a),  32'd1);
      check("hold_busy", 32'(busy_a), 32'd1);
    end
    check("hold_mem20", 32'(u_a.Mem[9'h020]), 32'h55);
    check("hold_mem21", 32'(u_a.Mem[9'h021]), 32'h00);
    @(negedge clk) mov_a = 1'b0;
    @(posedge clk); #1;
    check("hold_release_moc",  32'(moc_a),  32'd0);
    check("hold_release_busy", 32'(busy_a), 32'd0);
    check("hold_dout",         dout_a, 32'hFFFFF00D);

    // Reset asserted while in WAIT aborts the write.
    @(negedge clk);
    rw = 1'b0; size = 2'b10; sgn = 1'b0; addr = 9'h010; din = 32'hDEADBEEF; mov_a = 1'b1;
    @(posedge clk); #1;
    check("rstw_busy_before", 32'(busy_a), 32'd1);
    @(negedge clk) reset = 1'b0;
    #1;
    check("rstw_dout", dout_a, 32'h0);
    check("rstw_moc",  32'(moc_a),  32'd0);
    check("rstw_busy", 32'(busy_a), 32'd0);
    check("rstw_err",  32'(err_a),  32'd0);
    mov_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstw_mem10", 32'(u_a.Mem[9'h010]), 32'h01);
    check("rstw_mem11", 32'(u_a.Mem[9'h011]), 32'h02);
    check("rstw_mem12", 32'(u_a.Mem[9'h012]), 32'h03);
    check("rstw_mem13", 32'(u_a.Mem[9'h013]), 32'h04);
    check("rstw_mem2_kept", 32'(u_a.Mem[9'h002]), 32'h11);
    run_req(mk(1'b0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0BADF00D, 32'h00000000, 1'b0));
    run_req(mk(1'b0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'h0BADF00D, 1'b0));
    check("rstw_mem10_new", 32'(u_a.Mem[9'h010]), 32'h0B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_hs_param.md
RAM_HS_PARAM -- requirements
Module: ram_hs_param

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the byte-address width; the depth is 2^ADDR_W bytes.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the added wait states per access (0..15).
REQ-003 The block SHALL have parameter BIG_ENDIAN, default 1; 1 means byte at addr is the most significant byte, 0 means little-endian.
REQ-004 One clock and one reset; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1: asynchronous active-low reset.
REQ-007 Port mov, input, 1: memory operation valid (request).
REQ-008 Port rw, input, 1: 1 = read, 0 = write.
REQ-009 Port size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 Port sgn, input, 1: sign-extend byte/halfword reads when 1; zero-extend when 0.
REQ-011 Port addr, input, ADDR_W: byte address.
REQ-012 Port data_in, input, 32: write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 Port data_out, output, 32: read data, right-aligned and extended.
REQ-014 Port moc, output, 1: memory operation complete.
REQ-015 Port busy, output, 1: high in any state other than IDLE.
REQ-016 Port align_err, output, 1: access rejected (misaligned or illegal size); valid while moc is high.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT, DONE and ERR.
REQ-018 In IDLE with mov=1, the block SHALL capture addr, rw, size, sgn and data_in at the clock edge; later changes on these inputs SHALL be ignored until the next IDLE.
REQ-019 The capture SHALL go to ERR when size=11, when size=01 with addr[0]=1, or when size=10 with addr[1:0]!=00; otherwise it SHALL go to WAIT with cnt=WAIT_CYCLES.
REQ-020 In WAIT, each edge with cnt>0 SHALL decrement cnt; the edge with cnt=0 SHALL perform the access and go to DONE.
REQ-021 Latency: moc SHALL first be high after edge C+WAIT_CYCLES+1, where C is the capture edge; with WAIT_CYCLES=0 it is high after edge C+1.
REQ-022 A write SHALL commit to the array only on the WAIT->DONE edge, for 1, 2 or 4 bytes per size, with byte order per BIG_ENDIAN.
REQ-023 A read SHALL load data_out on the WAIT->DONE edge; data_out SHALL hold its value until the next completed read or reset.
REQ-024 In DONE, moc SHALL be 1 and align_err 0; DONE SHALL be held while mov=1 (four-phase handshake); mov=0 SHALL return the FSM to IDLE with moc=0 on that edge.
REQ-025 In ERR, moc SHALL be 1 and align_err 1, with no array write and data_out unchanged; ERR SHALL be held while mov=1; mov=0 SHALL return the FSM to IDLE.
REQ-026 mov SHALL be ignored in WAIT; a new request SHALL be captured only in IDLE, so mov held high across a return to IDLE does not restart an access.
REQ-027 From IDLE, the first edge with mov=1 SHALL capture; re-arming requires mov=0 to be seen in DONE/ERR.
REQ-028 Addresses SHALL occupy ADDR_W bits; a word at the top aligned address SHALL NOT wrap beyond 2^ADDR_W-1.
REQ-029 The array SHALL be a plain reg array named Mem, indexed by byte, so that benches can preload it hierarchically.

Reset
REQ-030 Reset low SHALL immediately force state IDLE, cnt=0, moc=0, busy=0, align_err=0 and data_out=0.
REQ-031 Reset low SHALL NOT clear the array contents.
REQ-032 Reset asserted in WAIT SHALL abort the access, with no array write.
REQ-033 After reset is released, the first edge with mov=1 SHALL be a fresh capture.

Verification
REQ-034 Word write and read-back, WAIT_CYCLES=2, BIG_ENDIAN=1:
- Stimulus: write 0x12345678 at addr 0x004, then read a word at 0x004.
- Response: Mem[4..7] = 12,34,56,78; data_out = 0x12345678; moc rises after edge C+3.
REQ-035 Byte reads of Mem[5]=0x9A:
- Stimulus: read a byte at 0x005 with sgn=1, then with sgn=0.
- Response: data_out = 0xFFFFFF9A, then 0x0000009A.
REQ-036 Misaligned halfword write:
- Stimulus: halfword write at addr 0x003.
- Response: moc=1 and align_err=1 one edge after capture; Mem unchanged; busy=1 until mov=0.
REQ-037 Reset during WAIT:
- Stimulus: word write at 0x010, then reset low on the cycle after capture.
- Response: Mem[0x10..0x13] unchanged; all outputs 0; a later request completes normally.
REQ-038 Handshake hold:
- Stimulus: keep mov high 5 cycles after moc rises.
- Response: moc stays 1; exactly one array write; IDLE one edge after mov=0.
REQ-039 WAIT_CYCLES=0, BIG_ENDIAN=0:
- Stimulus: write word 0xAABBCCDD at 0x1FC.
- Response: Mem[0x1FC] = DD and Mem[0x1FF] = AA; moc high after edge C+1.
